mesi_snoop_responder: RTL and testbench

//  L2 snoop side of MESI: services one snooped bus op at a time (SNOOPED_RD, SNOOP_WR,

---
 rtl/mesi_snoop_responder_pkg.sv | 59 +++++
 rtl/mesi_snoop_next.sv | 71 +++++++
 rtl/mesi_snoop_responder.sv | 153 +++++++++++++++
 tb/tb_mesi_snoop_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_snoop_responder_pkg.sv
// Shared types, geometry and address-split helpers for the L2 MESI snoop responder.
package mesi_snoop_responder_pkg;

  localparam int ADDR_W  = 32;
  localparam int WAYS    = 8;
  localparam int WAY_W   = $clog2(WAYS);
  localparam int INDEX_W = 14;
  localparam int OFFS_W  = 6;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;

  typedef enum logic [3:0] {
    CMD_SNOOP_INVAL  = 4'd3,
    CMD_SNOOPED_RD   = 4'd4,
    CMD_SNOOP_WR     = 4'd5,
    CMD_SNOOP_RDWITM = 4'd6
  } command_t;

  typedef enum logic [1:0] {MESI_M = 2'd0, MESI_E = 2'd1, MESI_S = 2'd2, MESI_I = 2'd3} mesi_t;

  typedef enum logic [1:0] {RES_HIT = 2'b00, RES_HITM = 2'b01, RES_NOHIT = 2'b10} snoop_res_t;

  typedef enum logic [2:0] {
    L1_NONE           = 3'd0,
    L1_GETLINE        = 3'd1,
    L1_SENDLINE       = 3'd2,
    L1_INVALIDATELINE = 3'd3,
    L1_EVICTLINE      = 3'd4
  } l2l1_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INVALIDATE = 3'd3, BUS_RWIM = 3'd4
  } busop_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_DECIDE, ST_L1MSG, ST_WB, ST_COMMIT
  } state_t;

  typedef struct packed {
    snoop_res_t res;
    logic       l1_act;
    l2l1_t      l1_msg;
    logic       wb;
    mesi_t      next;
    logic       err;
  } snoop_dec_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFS_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mesi_snoop_next.sv
// Combinational snoop action table: (command, hit, current MESI) -> result, L1 message,
// writeback need, next MESI state and protocol-error flag.
module mesi_snoop_next
  import mesi_snoop_responder_pkg::*;
(
  input  logic [3:0]  cmd_i,
  input  logic        hit_i,
  input  logic [1:0]  mesi_i,
  output snoop_dec_t  dec_o
);

  mesi_t cur;
  assign cur = hit_i ? mesi_t'(mesi_i) : MESI_I;

  always_comb begin
    dec_o        = '0;
    dec_o.res    = RES_NOHIT;
    dec_o.l1_msg = L1_NONE;
    dec_o.next   = cur;
    case (cmd_i)
      CMD_SNOOPED_RD: begin
        case (cur)
          MESI_E, MESI_S: begin
            dec_o.res  = RES_HIT;
            dec_o.next = MESI_S;
          end
          MESI_M: begin
            dec_o.res    = RES_HITM;
            dec_o.l1_act = 1'b1;
            dec_o.l1_msg = L1_GETLINE;
            dec_o.wb     = 1'b1;
            dec_o.next   = MESI_S;
          end
          default: ;
        endcase
      end
      CMD_SNOOP_RDWITM: begin
        case (cur)
          MESI_E, MESI_S: begin
            dec_o.res    = RES_HIT;
            dec_o.l1_act = 1'b1;
            dec_o.l1_msg = L1_INVALIDATELINE;
            dec_o.next   = MESI_I;
          end
          MESI_M: begin
            dec_o.res    = RES_HITM;
            dec_o.l1_act = 1'b1;
            dec_o.l1_msg = L1_EVICTLINE;
            dec_o.wb     = 1'b1;
            dec_o.next   = MESI_I;
          end
          default: ;
        endcase
      end
      CMD_SNOOP_INVAL: begin
        // An invalidate against an exclusively owned line means another owner exists.
        if (cur == MESI_S) begin
          dec_o.res    = RES_HIT;
          dec_o.l1_act = 1'b1;
          dec_o.l1_msg = L1_INVALIDATELINE;
          dec_o.next   = MESI_I;
        end else if (cur == MESI_E || cur == MESI_M) begin
          dec_o.err = 1'b1;
        end
      end
      CMD_SNOOP_WR: dec_o.err = (cur == MESI_E || cur == MESI_M);
      default:      dec_o.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mesi_snoop_responder.sv
// L2 snoop responder: one snooped bus op at a time through lookup, decide, optional L1
// message, optional dirty writeback and MESI commit.
module mesi_snoop_responder
  import mesi_snoop_responder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               snp_valid,
  output logic               snp_ready,
  input  logic [3:0]         snp_cmd,
  input  logic [ADDR_W-1:0]  snp_addr,
  output logic               lk_en,
  output logic [INDEX_W-1:0] lk_index,
  output logic [TAG_W-1:0]   lk_tag,
  input  logic               lk_hit,
  input  logic [WAY_W-1:0]   lk_way,
  input  logic [1:0]         lk_mesi,
  output logic               res_valid,
  output logic [1:0]         res,
  output logic               l1_valid,
  output logic [2:0]         l1_msg,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [2:0]         bus_op,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic               upd_valid,
  output logic [INDEX_W-1:0] upd_index,
  output logic [WAY_W-1:0]   upd_way,
  output logic [1:0]         upd_mesi,
  output logic               proto_err,
  output logic               done
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        cmd_q;
  logic [WAY_W-1:0]  way_q;
  mesi_t             next_q;
  l2l1_t             l1_msg_q;
  logic              wb_q, chg_q;
  logic              snp_ready_q, lk_en_q, l1_valid_q, bus_valid_q, upd_valid_q, done_q;
  snoop_dec_t        dec_d;
  mesi_t             cur_d;
  logic              in_decide;

  mesi_snoop_next u_next (
    .cmd_i  (cmd_q),
    .hit_i  (lk_hit),
    .mesi_i (lk_mesi),
    .dec_o  (dec_d)
  );

  assign cur_d     = lk_hit ? mesi_t'(lk_mesi) : MESI_I;
  assign in_decide = (state_q == ST_DECIDE);

  // The lookup answer is only present during DECIDE, so the result is driven straight from it.
  assign res_valid = in_decide;
  assign res       = in_decide ? dec_d.res : 2'b00;
  assign proto_err = in_decide & dec_d.err;

  assign snp_ready = snp_ready_q;
  assign lk_en     = lk_en_q;
  assign lk_index  = get_index(addr_q);
  assign lk_tag    = get_tag(addr_q);
  assign l1_valid  = l1_valid_q;
  assign l1_msg    = l1_valid_q ? l1_msg_q : L1_NONE;
  assign bus_valid = bus_valid_q;
  assign bus_op    = bus_valid_q ? BUS_WRITE : BUS_NONE;
  assign bus_addr  = line_addr(addr_q);
  assign upd_valid = upd_valid_q;
  assign upd_index = get_index(addr_q);
  assign upd_way   = way_q;
  assign upd_mesi  = next_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cmd_q       <= '0;
      way_q       <= '0;
      next_q      <= MESI_M;
      l1_msg_q    <= L1_NONE;
      wb_q        <= 1'b0;
      chg_q       <= 1'b0;
      snp_ready_q <= 1'b1;
      lk_en_q     <= 1'b0;
      l1_valid_q  <= 1'b0;
      bus_valid_q <= 1'b0;
      upd_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      lk_en_q     <= 1'b0;
      l1_valid_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (snp_valid) begin
            addr_q      <= snp_addr;
            cmd_q       <= snp_cmd;
            lk_en_q     <= 1'b1;
            snp_ready_q <= 1'b0;
            state_q     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_q <= ST_DECIDE;
        ST_DECIDE: begin
          way_q    <= lk_way;
          next_q   <= dec_d.next;
          l1_msg_q <= dec_d.l1_msg;
          wb_q     <= dec_d.wb;
          chg_q    <= (dec_d.next != cur_d);
          if (dec_d.l1_act) begin
            l1_valid_q <= 1'b1;
            state_q    <= ST_L1MSG;
          end else if (dec_d.wb) begin
            bus_valid_q <= 1'b1;
            state_q     <= ST_WB;
          end else begin
            upd_valid_q <= (dec_d.next != cur_d);
            done_q      <= 1'b1;
            state_q     <= ST_COMMIT;
          end
        end
        ST_L1MSG: begin
          if (wb_q) begin
            bus_valid_q <= 1'b1;
            state_q     <= ST_WB;
          end else begin
            upd_valid_q <= chg_q;
            done_q      <= 1'b1;
            state_q     <= ST_COMMIT;
          end
        end
        ST_WB: begin
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            upd_valid_q <= chg_q;
            done_q      <= 1'b1;
            state_q     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          snp_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Randomized scoreboard bench for mesi_snoop_responder with a rule-level reference model.
module tb_mesi_snoop_responder;
  import mesi_snoop_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               snp_valid = 1'b0;
  logic               snp_ready;
  logic [3:0]         snp_cmd = '0;
  logic [ADDR_W-1:0]  snp_addr = '0;
  logic               lk_en;
  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit = 1'b0;
  logic [WAY_W-1:0]   lk_way = '0;
  logic [1:0]         lk_mesi = '0;
  logic               res_valid;
  logic [1:0]         res;
  logic               l1_valid;
  logic [2:0]         l1_msg;
  logic               bus_valid;
  logic               bus_ready;
  logic [2:0]         bus_op;
  logic [ADDR_W-1:0]  bus_addr;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic [WAY_W-1:0]   upd_way;
  logic [1:0]         upd_mesi;
  logic               proto_err;
  logic               done;

  mesi_snoop_responder dut (
    .clk(clk), .rst(rst), .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd),
    .snp_addr(snp_addr), .lk_en(lk_en), .lk_index(lk_index), .lk_tag(lk_tag), .lk_hit(lk_hit),
    .lk_way(lk_way), .lk_mesi(lk_mesi), .res_valid(res_valid), .res(res), .l1_valid(l1_valid),
    .l1_msg(l1_msg), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
    .bus_addr(bus_addr), .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way),
    .upd_mesi(upd_mesi), .proto_err(proto_err), .done(done)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  res;
    logic [2:0]  l1;
    logic        wb;
    logic        upd;
    logic [1:0]  next;
    logic        err;
    logic [2:0]  way;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_stall = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Codes: cmd INVAL=3 RD=4 WR=5 RDWITM=6; res HIT=0 HITM=1 NOHIT=2; L1 GETLINE=1 INVALIDATELINE=3 EVICTLINE=4.
  function automatic exp_t model(input logic [3:0] cmd, input logic hit, input mesi_t m);
    exp_t  e;
    mesi_t cur;
    cur   = hit ? m : MESI_I;
    e     = '{default: '0};
    e.cmd = cmd;
    e.res = 2'd2;
    e.next = cur;
    if (cmd == 4'd4 || cmd == 4'd6) begin
      e.wb  = (cur == MESI_M);
      e.res = (cur == MESI_M) ? 2'd1 : (cur == MESI_I) ? 2'd2 : 2'd0;
      if (cmd == 4'd4) begin
        e.next = (cur == MESI_I) ? MESI_I : MESI_S;
        e.l1   = e.wb ? 3'd1 : 3'd0;
      end else begin
        e.next = MESI_I;
        e.l1   = e.wb ? 3'd4 : ((cur == MESI_I) ? 3'd0 : 3'd3);
      end
    end else if (cmd == 4'd3) begin
      e.err = (cur == MESI_E || cur == MESI_M);
      if (cur == MESI_S) begin
        e.res  = 2'd0;
        e.l1   = 3'd3;
        e.next = MESI_I;
      end
    end else if (cmd == 4'd5) begin
      e.err = (cur == MESI_E || cur == MESI_M);
    end else begin
      e.err = 1'b1;
    end
    e.upd = (e.next != cur);
    return e;
  endfunction

  task automatic do_snoop(input logic [3:0] cmd, input logic [31:0] addr, input logic hit,
                          input mesi_t m, input logic [2:0] way, input int stall,
                          input bit hold, input bit track);
    exp_t e;
    int   guard;
    guard = 0;
    while (snp_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("ready_wait", snp_ready, 1);
    e       = model(cmd, hit, m);
    e.addr  = addr;
    e.way   = way;
    e.stall = stall;
    if (track) exp_q.push_back(e);
    cur_stall = stall;
    snp_valid = 1'b1;
    snp_cmd   = cmd;
    snp_addr  = addr;
    @(posedge clk); #1;
    if (!hold) begin
      snp_valid = 1'b0;
      snp_cmd   = 4'($urandom);
      snp_addr  = $urandom;
    end
    lk_hit  = 1'($urandom);
    lk_way  = 3'($urandom);
    lk_mesi = 2'($urandom);
    @(posedge clk); #1;
    lk_hit  = hit;
    lk_way  = way;
    lk_mesi = hit ? m : MESI_I;
  endtask

  // Writeback acceptor: holds bus_ready low for cur_stall cycles of bus_valid, random otherwise.
  int bcnt = 0;
  initial begin
    bus_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus_valid) begin
        bus_ready = (bcnt == cur_stall);
        bcnt++;
      end else begin
        bcnt = 0;
        bus_ready = 1'($urandom);
      end
    end
  end

  // Monitor: gathers everything the DUT shows for one snoop, scores it on done.
  int          cyc = 0, acc_cyc = 0, txn_n = 0;
  bit          in_flight = 0, stray = 0, ready_viol = 0, bus_unstable = 0;
  int          lk_n, lk_cyc, res_n, res_cyc, err_n, l1_n, bus_n, upd_n;
  logic [13:0] lk_idx, upd_i;
  logic [11:0] lk_tg;
  logic [1:0]  res_v, upd_m;
  logic [2:0]  l1_m, bus_o, upd_w;
  logic [31:0] bus_a;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      in_flight = 0;
    end else if (!in_flight) begin
      if (res_valid | l1_valid | bus_valid | upd_valid | proto_err | done | lk_en) stray = 1;
      if (snp_valid && snp_ready) begin
        in_flight = 1; acc_cyc = cyc; ready_viol = 0; bus_unstable = 0;
        lk_n = 0; res_n = 0; err_n = 0; l1_n = 0; bus_n = 0; upd_n = 0;
      end
    end else begin
      if (snp_ready) ready_viol = 1;
      if (lk_en) begin lk_n++; lk_cyc = cyc; lk_idx = lk_index; lk_tg = lk_tag; end
      if (res_valid) begin res_n++; res_cyc = cyc; res_v = res; end
      if (proto_err) err_n++;
      if (l1_valid) begin l1_n++; l1_m = l1_msg; end
      if (bus_valid) begin
        if (bus_n == 0) begin bus_a = bus_addr; bus_o = bus_op; end
        else if (bus_addr !== bus_a || bus_op !== bus_o) bus_unstable = 1;
        bus_n++;
      end
      if (upd_valid) begin upd_n++; upd_i = upd_index; upd_w = upd_way; upd_m = upd_mesi; end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lk_count", lk_n, 1);
          chk("lk_latency", lk_cyc - acc_cyc, 1);
          chk("lk_index", lk_idx, (e.addr >> 6) & 32'h3fff);
          chk("lk_tag", lk_tg, e.addr >> 20);
          chk("res_count", res_n, 1);
          chk("res_latency", res_cyc - acc_cyc, 2);
          chk("res", res_v, e.res);
          chk("proto_err", err_n, e.err);
          chk("l1_count", l1_n, e.l1 != 0);
          if (e.l1 != 0) chk("l1_msg", l1_m, e.l1);
          chk("bus_cycles", bus_n, e.wb ? e.stall + 1 : 0);
          if (e.wb) begin
            chk("bus_addr", bus_a, e.addr & ~32'h3f);
            chk("bus_op", bus_o, 2);
            chk("bus_stable", bus_unstable, 0);
          end
          chk("upd_count", upd_n, e.upd);
          if (e.upd) begin
            chk("upd_index", upd_i, (e.addr >> 6) & 32'h3fff);
            chk("upd_way", upd_w, e.way);
            chk("upd_mesi", upd_m, e.next);
          end
          chk("ready_low", ready_viol, 0);
          chk("done_latency", cyc - acc_cyc, 3 + (e.l1 != 0) + (e.wb ? e.stall + 1 : 0));
          $display("txn %0d cmd=%0d addr=%h res=%0d l1=%0d wb_cycles=%0d upd=%0d next=%0d err=%0d",
                   txn_n, e.cmd, e.addr, res_v, l1_n ? l1_m : 3'd0, bus_n, upd_n, e.next, err_n);
          txn_n++;
        end
        in_flight = 0;
      end
    end
  end

  initial begin
    int    guard;
    int    r;
    mesi_t m;
    logic [3:0] cmd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_snp_ready", snp_ready, 1);
    chk("rst_lk_en", lk_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_l1_valid", l1_valid, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_op", bus_op, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_snoop(4'd4, $urandom, 1'b1, MESI_E, 3'd3, 0, 0, 1);
    do_snoop(4'd4, 32'h1234_5678, 1'b1, MESI_M, 3'd5, 5, 0, 1);
    do_snoop(4'd6, $urandom, 1'b1, MESI_S, 3'd1, 0, 0, 1);
    do_snoop(4'd6, $urandom, 1'b1, MESI_M, 3'd6, 2, 0, 1);
    do_snoop(4'd3, $urandom, 1'b0, MESI_I, 3'd0, 0, 0, 1);
    do_snoop(4'd3, $urandom, 1'b1, MESI_E, 3'd2, 0, 0, 1);
    do_snoop(4'd4, $urandom, 1'b1, MESI_S, 3'd4, 0, 1, 1);
    do_snoop(4'd5, $urandom, 1'b1, MESI_M, 3'd7, 0, 0, 1);
    do_snoop(4'd9, $urandom, 1'b1, MESI_M, 3'd2, 0, 0, 1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      cmd = 4'd3;
      else if (r < 4) cmd = 4'd4;
      else if (r < 6) cmd = 4'd5;
      else if (r < 8) cmd = 4'd6;
      else            cmd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(7, 15));
      r = $urandom_range(0, 2);
      m = (r == 0) ? MESI_M : (r == 1) ? MESI_E : MESI_S;
      do_snoop(cmd, $urandom, ($urandom_range(0, 3) != 0), m, 3'($urandom),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1);
    end
    do_snoop(4'd5, $urandom, 1'b1, MESI_S, 3'd1, 0, 0, 1);

    // Reset while a writeback is stalled: nothing of that snoop may surface afterwards.
    do_snoop(4'd4, $urandom, 1'b1, MESI_M, 3'd2, 1000, 0, 0);
    guard = 0;
    while (!bus_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wb_reached", bus_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_bus_valid", bus_valid, 0);
    chk("midrst_snp_ready", snp_ready, 1);
    chk("midrst_upd_valid", upd_valid, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_commit", upd_valid, 0);
    do_snoop(4'd4, $urandom, 1'b1, MESI_E, 3'd0, 0, 0, 1);

    guard = 0;
    while ((exp_q.size() != 0 || in_flight) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain", exp_q.size(), 0);
    chk("idle_quiet", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
